// File: rtl/rxstream_arbiter.sv
// rxstream_arbiter: round-robin merge of N_SRC 32-bit valid/ready streams
// into the single rx stream input of the wishbone rx FIFO bridge.
// Each grant costs one arbitration cycle and lasts at most BURST_MAX words.
// Optional build macro: RXARB_HEADER_EN adds a header word
// {8'hA5, src[3:0], 4'h0, seq[15:0]} in front of every burst.
module rxstream_arbiter #(
  parameter int N_SRC     = 4,
  parameter int BURST_MAX = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_SRC-1:0]      i_src_en,
  input  logic [N_SRC-1:0]      i_src_valid,
  output logic [N_SRC-1:0]      o_src_ready,
  input  logic [N_SRC*32-1:0]   i_src_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [31:0]           o_data,
  output logic [N_SRC-1:0]      o_grant,
  output logic                  o_active
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W  = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};

`ifdef RXARB_HEADER_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_XFER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd2} state_t;
`endif

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef RXARB_HEADER_EN
  logic [15:0]        seq_q, seq_d;
`endif

  logic [DATA_W-1:0]  src_data [N_SRC];
  logic [N_SRC-1:0]   req;
  logic               arb_hit;
  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   arb_cand;
  logic               g_vld;
  logic               g_en;

  // Unpack the flat source data bus into one word per source
  for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
    assign src_data[k] = i_src_data[DATA_W*k +: DATA_W];
  end

  // Round-robin search: first requester above the last-grant pointer, wrapping
  always_comb begin
    req      = i_src_valid & i_src_en;
    arb_hit  = 1'b0;
    arb_idx  = ptr_q;
    arb_cand = ptr_q;
    for (int i = 1; i <= N_SRC; i++) begin
      arb_cand = PTR_W'((int'(ptr_q) + i) % N_SRC);
      if (!arb_hit && req[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  // Next-state and stream outputs; the granted source is the pointer index
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
`ifdef RXARB_HEADER_EN
    seq_d       = seq_q;
`endif
    o_valid     = 1'b0;
    o_data      = '0;
    o_src_ready = '0;
    g_vld       = i_src_valid[ptr_q];
    g_en        = i_src_en[ptr_q];

    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          grant_d = ONE_HOT0 << arb_idx;
          ptr_d   = arb_idx;
`ifdef RXARB_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_XFER;
`endif
        end
      end
`ifdef RXARB_HEADER_EN
      S_HDR: begin
        o_valid = 1'b1;
        o_data  = {8'hA5, 4'(ptr_q), 4'h0, seq_q};
        if (i_ready) begin
          seq_d   = seq_q + 16'd1;
          state_d = S_XFER;
        end
      end
`endif
      S_XFER: begin
        o_valid     = g_vld & g_en;
        o_data      = src_data[ptr_q];
        o_src_ready = grant_q & {N_SRC{i_ready & g_en}};
        if (!g_vld || !g_en) begin
          // Source gap or disable ends the burst without a transfer
          state_d = S_IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else if (i_ready) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            grant_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  assign o_grant  = grant_q;
  assign o_active = (state_q != S_IDLE);

  // State register; pointer resets to the top so source 0 wins first
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(N_SRC - 1);
      cnt_q   <= '0;
`ifdef RXARB_HEADER_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef RXARB_HEADER_EN
      seq_q   <= seq_d;
`endif
    end
  end

endmodule

// File: tb/tb_rxstream_arbiter.sv
// Directed bench for rxstream_arbiter (N_SRC=4, BURST_MAX=8).
// When built with RXARB_HEADER_EN, each burst also expects its header word.
module tb_rxstream_arbiter;

  localparam int N_SRC     = 4;
  localparam int BURST_MAX = 8;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [N_SRC-1:0]    i_src_en;
  logic [N_SRC-1:0]    i_src_valid;
  logic [N_SRC-1:0]    o_src_ready;
  logic [N_SRC*32-1:0] i_src_data;
  logic                o_valid;
  logic                i_ready;
  logic [31:0]         o_data;
  logic [N_SRC-1:0]    o_grant;
  logic                o_active;

  int errors = 0;
  int checks = 0;
`ifdef RXARB_HEADER_EN
  logic [15:0] seq_exp = 16'h0000;
`endif

  rxstream_arbiter #(.N_SRC(N_SRC), .BURST_MAX(BURST_MAX)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_src_en    (i_src_en),
    .i_src_valid (i_src_valid),
    .o_src_ready (o_src_ready),
    .i_src_data  (i_src_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_grant     (o_grant),
    .o_active    (o_active)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One XFER word from source src carrying value d, with i_ready high
  task automatic word(input int src, input logic [31:0] d);
    i_src_data[src*32 +: 32] = d;
    #1;
    chk("word_valid", 32'(o_valid), 32'd1);
    chk("word_data", o_data, d);
    chk("word_grant", 32'(o_grant), 32'd1 << src);
    chk("word_ready", 32'(o_src_ready), 32'd1 << src);
    chk("word_active", 32'(o_active), 32'd1);
    cyc();
  endtask

  // Arbitration bubble (current cycle), optional header, then n words
  task automatic burst(input int src, input int n, input logic [31:0] base);
    #1;
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_grant", 32'(o_grant), 32'd0);
    chk("idle_active", 32'(o_active), 32'd0);
    cyc();
`ifdef RXARB_HEADER_EN
    #1;
    chk("hdr_valid", 32'(o_valid), 32'd1);
    chk("hdr_data", o_data, {8'hA5, 4'(src), 4'h0, seq_exp});
    chk("hdr_ready", 32'(o_src_ready), 32'd0);
    chk("hdr_grant", 32'(o_grant), 32'd1 << src);
    seq_exp = seq_exp + 16'd1;
    cyc();
`endif
    for (int w = 0; w < n; w++) word(src, base + 32'(w));
  endtask

  initial begin
    i_rst       = 1'b1;
    i_src_en    = 4'b1111;
    i_src_valid = 4'b1111;
    i_src_data  = '0;
    i_ready     = 1'b1;
    cyc();
    cyc();
    // Reset state, even with every source requesting
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_src_ready), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_active", 32'(o_active), 32'd0);

    // Single source: two full bursts with one bubble between
    i_rst       = 1'b0;
    i_src_valid = 4'b0001;
    burst(0, 8, 32'hA000_0000);
    burst(0, 8, 32'hA100_0000);
    // Third burst truncated by reset mid-way
    burst(0, 3, 32'hA200_0000);
    i_rst = 1'b1;
    cyc();
    #1;
    chk("rstmid_valid", 32'(o_valid), 32'd0);
    chk("rstmid_ready", 32'(o_src_ready), 32'd0);
    chk("rstmid_grant", 32'(o_grant), 32'd0);
    chk("rstmid_active", 32'(o_active), 32'd0);
`ifdef RXARB_HEADER_EN
    seq_exp = 16'h0000;
`endif

    // All sources valid: grant order 0,1,2,3,0
    i_rst       = 1'b0;
    i_src_valid = 4'b1111;
    burst(0, 8, 32'h0000_0100);
    burst(1, 8, 32'h1111_0200);
    burst(2, 8, 32'h2222_0300);
    burst(3, 8, 32'h3333_0400);
    burst(0, 8, 32'h0000_0500);

    // src2 gives 3 words then drops; src1 follows after one bubble
    i_src_valid = 4'b0100;
    burst(2, 3, 32'h2C00_0000);
    i_src_valid = 4'b0010;
    #1;
    chk("gap_valid", 32'(o_valid), 32'd0);
    chk("gap_grant", 32'(o_grant), 32'h4);
    chk("gap_active", 32'(o_active), 32'd1);
    chk("gap_ready", 32'(o_src_ready), 32'h4);
    cyc();
    burst(1, 8, 32'h1C00_0000);

    // Backpressure: 5 stalled cycles after word 3, burst still 8 words
    burst(1, 3, 32'hBB00_0000);
    i_ready = 1'b0;
    i_src_data[1*32 +: 32] = 32'hBB00_0003;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_data", o_data, 32'hBB00_0003);
      chk("stall_ready", 32'(o_src_ready), 32'd0);
      chk("stall_grant", 32'(o_grant), 32'h2);
      cyc();
    end
    i_ready = 1'b1;
    for (int w = 3; w < 8; w++) word(1, 32'hBB00_0000 + 32'(w));
    #1;
    chk("bp_end_valid", 32'(o_valid), 32'd0);
    chk("bp_end_grant", 32'(o_grant), 32'd0);
    i_src_valid = 4'b0000;
    cyc();

    // Source 2 masked off: rotation skips it
    i_src_en    = 4'b1011;
    i_src_valid = 4'b1111;
    burst(3, 8, 32'h3E00_0000);
    burst(0, 8, 32'h0E00_0000);
    burst(1, 8, 32'h1E00_0000);
    burst(3, 2, 32'h3F00_0000);
    // Disable the granted source mid-burst
    i_src_en = 4'b0011;
    #1;
    chk("dis_valid", 32'(o_valid), 32'd0);
    chk("dis_ready", 32'(o_src_ready), 32'd0);
    chk("dis_grant", 32'(o_grant), 32'h8);
    chk("dis_active", 32'(o_active), 32'd1);
    i_src_valid = 4'b0000;
    cyc();
    #1;
    chk("dis_idle_valid", 32'(o_valid), 32'd0);
    chk("dis_idle_grant", 32'(o_grant), 32'd0);
    chk("dis_idle_active", 32'(o_active), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
